br_resolve: RTL and testbench
=============================

# br_resolve

Branch resolution unit; the execute-side counterpart of the fetch-stage branch predictor. It records every prediction fetch makes in an in-order queue, checks each prediction against the actual outcome when execute resolves the branch, and returns `mispred`, `flush`, `correct_pc` and `index_pc` to the predictor. It also emits a training strobe for BHT/RAS update. It sits between the fetch-stage `bp` and the integer execute stage.

## Interface
- `DEPTH`, 8, in-flight prediction queue entries; power of two, ≥2
- `PCW`, 48, PC width
- `clk`  in  1  clock
- `n_reset`  in  1  reset, asynchronous, active-low
- `enq_valid`  in  1  fetch presents a predicted control-flow instruction
- `enq_ready`  out  1  queue can accept; `!full && !flush`
- `enq_pc`  in  PCW  PC of the predicted instruction
- `enq_pred_pc`  in  PCW  predicted next PC (`pc+4` when predicted not-taken)
- `enq_pred_taken`  in  1  prediction direction
- `res_valid`  in  1  execute resolves the oldest outstanding branch
- `res_pc`  in  PCW  PC of the resolving instruction
- `res_taken`  in  1  actual direction
- `res_target`  in  PCW  actual target when taken
- `mispred`  out  1  registered pulse: prediction was wrong
- `flush`  out  1  registered pulse: younger work must be discarded
- `correct_pc`  out  PCW  redirect PC, valid with `mispred`
- `index_pc`  out  PCW  PC of the mispredicted branch, valid with `mispred`/`upd_valid`
- `upd_valid`  out  1  registered pulse per resolved branch (train predictor)
- `upd_taken`  out  1  actual direction, valid with `upd_valid`
- `count`  out  $clog2(DEPTH)+1  entries held
- `err`  out  1  registered pulse: resolve with empty queue or PC mismatch

## Operation
- Enqueue: `enq_valid && enq_ready` writes `{pc, pred_pc, pred_taken}` at tail; tail increments modulo DEPTH.
- Resolve: `res_valid` with queue non-empty compares against head entry. `actual_next = res_taken ? res_target : res_pc + 4` (PCW-bit wrap).
- Correct: `actual_next == head.pred_pc` and `res_pc == head.pc`. Head is popped, `upd_valid`=1, and `mispred`/`flush` stay 0.
- Mispredict: `actual_next != head.pred_pc` and PCs match. Next cycle `mispred`=`flush`=`upd_valid`=1, `correct_pc=actual_next`, `index_pc=res_pc`, `upd_taken=res_taken`. All entries are discarded: head=tail=0, count=0.
- PC mismatch (`res_pc != head.pc`): treated as mispredict to `actual_next` and `err`=1. This is a recovery path only.
- `res_valid` with empty queue: no state change, `err`=1, no other outputs.
- Simultaneous enqueue and correct resolve: both happen; count is unchanged.
- Simultaneous enqueue and mispredicting resolve: the enqueue is dropped because it is wrong-path. `enq_ready` does not depend on `res_*`, so fetch must tolerate the drop.
- Full: `enq_ready`=0 even if a resolve pops in the same cycle. There is no bypass.
- `enq_ready`=0 in the cycle `flush` is high.

## Timing
- All outputs are registered except `enq_ready`, which is combinational from `count`/`flush` registers.
- Resolve-to-`mispred`/`upd_valid` latency is 1 cycle. Pulses are exactly 1 cycle wide.
- An enqueue is visible to resolve the cycle after acceptance.
- Reset values: `mispred`, `flush`, `upd_valid`, `upd_taken`, `err` = 0; `correct_pc` = `index_pc` = 0; `count` = 0; `enq_ready` = 1. Head and tail pointers are 0.
- Reset mid-operation discards every entry immediately and clears any pending pulse.

## Structure
- `bp_pkg`: `pred_entry_t` (packed pc/pred_pc/pred_taken), `JAL`/`JALR` opcode localparams, and the `PCW` default. These are shared with `bp`.
- Sub-module `pred_fifo`: DEPTH×`pred_entry_t` circular buffer with head/tail/count and a synchronous `clear`. `br_resolve` holds only the compare logic and the output registers.

## Test plan
- Enqueue pc=0x1000, pred_pc=0x1004, not-taken. Resolve taken=0 → `upd_valid`=1, `mispred`=0, `count` 1→0.
- Enqueue pc=0x2000, pred 0x2400 taken. Resolve taken, target 0x2800 → next cycle `mispred`=`flush`=1, `correct_pc`=0x2800, `index_pc`=0x2000, `count`=0.
- Fill 8 entries → `enq_ready`=0. A resolve and an enqueue in the same cycle → enqueue rejected, `count`=7.
- Resolve with empty queue → `err` pulses 1 cycle, `count` stays 0, `upd_valid`=0.
- Mispredicting resolve plus simultaneous enqueue of pc=0x3000 → `count`=0 afterwards, entry 0x3000 absent.
- With 3 entries queued, drop `n_reset` asynchronously mid-cycle → `count`=0 and all pulses 0 before the next edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Types and constants shared by the fetch-side predictor and
// the execute-side branch resolution unit.
package bp_pkg;

    localparam int BP_PCW = 48;

    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    typedef struct packed {
        logic [BP_PCW-1:0] pc;
        logic [BP_PCW-1:0] pred_pc;
        logic              pred_taken;
    } pred_entry_t;

    function automatic logic is_jump(input logic [6:0] opcode);
        return (opcode == JAL) || (opcode == JALR);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order circular buffer of outstanding predictions.
// A synchronous clear empties it and wins over push/pop.
module pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 2 * BP_PCW + 1,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (pop)  head_d = head_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[tail_q] <= wdata;
    end

    assign rdata = mem_q[head_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/br_resolve.sv
// Branch resolution: checks the oldest prediction against the
// executed outcome and drives redirect/training pulses.
module br_resolve
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PCW   = BP_PCW
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PCW-1:0]           enq_pc,
    input  logic [PCW-1:0]           enq_pred_pc,
    input  logic                     enq_pred_taken,
    input  logic                     res_valid,
    input  logic [PCW-1:0]           res_pc,
    input  logic                     res_taken,
    input  logic [PCW-1:0]           res_target,
    output logic                     mispred,
    output logic                     flush,
    output logic [PCW-1:0]           correct_pc,
    output logic [PCW-1:0]           index_pc,
    output logic                     upd_valid,
    output logic                     upd_taken,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * PCW + 1;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [PCW-1:0] pred_pc;
        logic           pred_taken;
    } entry_t;

    entry_t         wr_e, hd_e;
    logic [EW-1:0]  hd_raw;
    logic           fifo_full, fifo_empty;
    logic           unused_dir;

    logic           enq_acc, res_hit, pc_ok, pred_ok, good, bad;
    logic [PCW-1:0] actual_next;

    logic           mispred_q, mispred_d;
    logic           flush_q, flush_d;
    logic           upd_valid_q, upd_valid_d;
    logic           upd_taken_q, upd_taken_d;
    logic           err_q, err_d;
    logic [PCW-1:0] correct_pc_q, correct_pc_d;
    logic [PCW-1:0] index_pc_q, index_pc_d;

    assign wr_e = '{pc: enq_pc, pred_pc: enq_pred_pc,
                    pred_taken: enq_pred_taken};
    assign hd_e = entry_t'(hd_raw);
    assign unused_dir = hd_e.pred_taken;

    assign enq_ready   = !fifo_full && !flush_q;
    assign enq_acc     = enq_valid && enq_ready;
    assign res_hit     = res_valid && !fifo_empty;
    assign actual_next = res_taken ? res_target : res_pc + PCW'(4);
    assign pc_ok       = (res_pc == hd_e.pc);
    assign pred_ok     = (actual_next == hd_e.pred_pc);
    assign good        = res_hit && pc_ok && pred_ok;
    assign bad         = res_hit && !(pc_ok && pred_ok);

    // A wrong-path enqueue landing with a mispredict is dropped by clear.
    pred_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (enq_acc),
        .pop     (good),
        .clear   (bad),
        .wdata   (wr_e),
        .rdata   (hd_raw),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        mispred_d    = bad;
        flush_d      = bad;
        upd_valid_d  = res_hit;
        err_d        = res_valid && (fifo_empty || !pc_ok);
        upd_taken_d  = upd_taken_q;
        correct_pc_d = correct_pc_q;
        index_pc_d   = index_pc_q;
        if (res_hit) begin
            upd_taken_d = res_taken;
            index_pc_d  = res_pc;
        end
        if (bad) correct_pc_d = actual_next;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mispred_q    <= 1'b0;
            flush_q      <= 1'b0;
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            err_q        <= 1'b0;
            correct_pc_q <= '0;
            index_pc_q   <= '0;
        end else begin
            mispred_q    <= mispred_d;
            flush_q      <= flush_d;
            upd_valid_q  <= upd_valid_d;
            upd_taken_q  <= upd_taken_d;
            err_q        <= err_d;
            correct_pc_q <= correct_pc_d;
            index_pc_q   <= index_pc_d;
        end
    end

    assign mispred    = mispred_q;
    assign flush      = flush_q;
    assign upd_valid  = upd_valid_q;
    assign upd_taken  = upd_taken_q;
    assign err        = err_q;
    assign correct_pc = correct_pc_q;
    assign index_pc   = index_pc_q;

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: the driver queues expected pulses,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_br_resolve;

    localparam int PCW   = 48;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           n_reset;
    logic           enq_valid;
    logic           enq_ready;
    logic [PCW-1:0] enq_pc;
    logic [PCW-1:0] enq_pred_pc;
    logic           enq_pred_taken;
    logic           res_valid;
    logic [PCW-1:0] res_pc;
    logic           res_taken;
    logic [PCW-1:0] res_target;
    logic           mispred;
    logic           flush;
    logic [PCW-1:0] correct_pc;
    logic [PCW-1:0] index_pc;
    logic           upd_valid;
    logic           upd_taken;
    logic [CW-1:0]  count;
    logic           err;

    typedef struct {
        logic           mis;
        logic           upd;
        logic           tk;
        logic           err;
        logic [PCW-1:0] cpc;
        logic [PCW-1:0] ipc;
    } exp_t;

    exp_t sb[$];
    int   nchecks = 0;
    int   nerrs   = 0;

    br_resolve #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_pc         (enq_pc),
        .enq_pred_pc    (enq_pred_pc),
        .enq_pred_taken (enq_pred_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .mispred        (mispred),
        .flush          (flush),
        .correct_pc     (correct_pc),
        .index_pc       (index_pc),
        .upd_valid      (upd_valid),
        .upd_taken      (upd_taken),
        .count          (count),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (n_reset && (mispred || flush || upd_valid || err)) begin
            if (sb.size() == 0) begin
                nchecks++;
                nerrs++;
                $display("FAIL unexpected_pulse: mis=%0b fl=%0b upd=%0b err=%0b expected none",
                         mispred, flush, upd_valid, err);
            end else begin
                e = sb.pop_front();
                chk("mispred", 64'(mispred), 64'(e.mis));
                chk("flush", 64'(flush), 64'(e.mis));
                chk("upd_valid", 64'(upd_valid), 64'(e.upd));
                chk("err", 64'(err), 64'(e.err));
                if (e.upd) begin
                    chk("index_pc", 64'(index_pc), 64'(e.ipc));
                    chk("upd_taken", 64'(upd_taken), 64'(e.tk));
                end
                if (e.mis) chk("correct_pc", 64'(correct_pc), 64'(e.cpc));
            end
        end
    end

    task automatic push_exp(input logic mis, input logic er, input logic upd,
                            input logic tk, input logic [PCW-1:0] cpc,
                            input logic [PCW-1:0] ipc);
        exp_t e;
        e.mis = mis; e.err = er; e.upd = upd;
        e.tk = tk; e.cpc = cpc; e.ipc = ipc;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic set_enq(input logic [PCW-1:0] pc,
                           input logic [PCW-1:0] pp, input logic tk);
        enq_valid = 1'b1; enq_pc = pc; enq_pred_pc = pp; enq_pred_taken = tk;
    endtask

    task automatic set_res(input logic [PCW-1:0] pc, input logic tk,
                           input logic [PCW-1:0] tgt);
        res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
    endtask

    task automatic enq(input logic [PCW-1:0] pc,
                       input logic [PCW-1:0] pp, input logic tk);
        set_enq(pc, pp, tk);
        @(negedge clk);
        enq_valid = 1'b0;
    endtask

    task automatic res(input logic [PCW-1:0] pc, input logic tk,
                       input logic [PCW-1:0] tgt);
        set_res(pc, tk, tgt);
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic both(input logic [PCW-1:0] rpc, input logic rtk,
                        input logic [PCW-1:0] rtgt,
                        input logic [PCW-1:0] epc,
                        input logic [PCW-1:0] epp);
        set_res(rpc, rtk, rtgt);
        set_enq(epc, epp, 1'b0);
        @(negedge clk);
        res_valid = 1'b0;
        enq_valid = 1'b0;
    endtask

    initial begin
        n_reset = 1'b0;
        enq_valid = 1'b0; enq_pc = '0; enq_pred_pc = '0; enq_pred_taken = 1'b0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
        repeat (2) @(negedge clk);
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_mispred", 64'(mispred), 64'd0);
        n_reset = 1'b1;
        idle();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_correct_pc", 64'(correct_pc), 64'd0);
        chk("rst_index_pc", 64'(index_pc), 64'd0);

        // correct not-taken
        enq(48'h1000, 48'h1004, 1'b0);
        chk("cnt_after_enq", 64'(count), 64'd1);
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, '0, 48'h1000);
        res(48'h1000, 1'b0, 48'h0);
        chk("cnt_after_pop", 64'(count), 64'd0);

        // taken to wrong target
        enq(48'h2000, 48'h2400, 1'b1);
        push_exp(1'b1, 1'b0, 1'b1, 1'b1, 48'h2800, 48'h2000);
        res(48'h2000, 1'b1, 48'h2800);
        chk("cnt_after_mis", 64'(count), 64'd0);
        chk("ready_during_flush", 64'(enq_ready), 64'd0);
        idle();
        chk("ready_after_flush", 64'(enq_ready), 64'd1);

        // fill, then resolve+enqueue while full
        for (int i = 0; i < DEPTH; i++)
            enq(48'h100 + 48'(4 * i), 48'h104 + 48'(4 * i), 1'b0);
        chk("cnt_full", 64'(count), 64'd8);
        chk("ready_full", 64'(enq_ready), 64'd0);
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, '0, 48'h100);
        both(48'h100, 1'b0, 48'h0, 48'h500, 48'h504);
        chk("cnt_full_pop", 64'(count), 64'd7);
        for (int i = 1; i < DEPTH; i++) begin
            push_exp(1'b0, 1'b0, 1'b1, 1'b0, '0, 48'h100 + 48'(4 * i));
            res(48'h100 + 48'(4 * i), 1'b0, 48'h0);
        end
        chk("cnt_drained", 64'(count), 64'd0);

        // resolve on empty queue
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        res(48'h9000, 1'b0, 48'h0);
        chk("cnt_empty_res", 64'(count), 64'd0);

        // enqueue and correct resolve together
        enq(48'h1100, 48'h1104, 1'b0);
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, '0, 48'h1100);
        both(48'h1100, 1'b0, 48'h0, 48'h1200, 48'h1204);
        chk("cnt_enq_pop", 64'(count), 64'd1);
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, '0, 48'h1200);
        res(48'h1200, 1'b0, 48'h0);

        // mispredict drops the wrong-path enqueue
        enq(48'h4000, 48'h4004, 1'b0);
        push_exp(1'b1, 1'b0, 1'b1, 1'b1, 48'h4800, 48'h4000);
        both(48'h4000, 1'b1, 48'h4800, 48'h3000, 48'h3004);
        chk("cnt_wrong_path", 64'(count), 64'd0);
        idle();
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        res(48'h3000, 1'b0, 48'h0);
        chk("cnt_3000_absent", 64'(count), 64'd0);

        // PC mismatch recovery
        enq(48'h5000, 48'h5004, 1'b0);
        push_exp(1'b1, 1'b1, 1'b1, 1'b0, 48'h5104, 48'h5100);
        res(48'h5100, 1'b0, 48'h0);
        chk("cnt_pc_mismatch", 64'(count), 64'd0);
        idle();

        // pc+4 wraps at PCW bits
        enq(48'hFFFF_FFFF_FFFC, 48'h0, 1'b0);
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, '0, 48'hFFFF_FFFF_FFFC);
        res(48'hFFFF_FFFF_FFFC, 1'b0, 48'h0);
        chk("cnt_wrap", 64'(count), 64'd0);

        // asynchronous reset mid-cycle with a pulse pending
        for (int i = 0; i < 3; i++)
            enq(48'h6000 + 48'(4 * i), 48'h6004 + 48'(4 * i), 1'b0);
        chk("cnt_three", 64'(count), 64'd3);
        set_res(48'h6000, 1'b0, 48'h0);
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        res_valid = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_upd_valid", 64'(upd_valid), 64'd0);
        chk("arst_mispred", 64'(mispred), 64'd0);
        chk("arst_flush", 64'(flush), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        chk("arst_enq_ready", 64'(enq_ready), 64'd1);
        @(negedge clk);
        n_reset = 1'b1;
        idle();
        chk("post_rst_count", 64'(count), 64'd0);
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        res(48'h6004, 1'b0, 48'h0);

        repeat (3) idle();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "timeout");
    end

endmodule
